// File: rtl/ahb_lite_sram_slv.sv
// AHB-Lite subordinate backed by a register-array memory with a fixed number of
// wait states per OKAY transfer and a two-cycle ERROR response.
module ahb_lite_sram_slv #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int IW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        st_q, st_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    lo_q, lo_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;

  logic [31:0]   mem [MEM_DEPTH];
  logic          capture;
  logic          addr_err;
  logic [3:0]    be;
  logic          unused_in;

  assign unused_in = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
  assign capture   = HSEL & HREADY & HTRANS[1];

  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > 3'd2)                            addr_err = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0])               addr_err = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)    addr_err = 1'b1;
    if ({2'b00, HADDR[31:2]} >= 32'(MEM_DEPTH))  addr_err = 1'b1;
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    size_d  = size_q;
    write_d = write_q;
    case (st_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          st_d  = ST_ACCESS;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: st_d = ST_ERR2;
      default: begin
        // IDLE, ACCESS and ERR2 all end with HREADY high, so a new address phase is taken here
        st_d = ST_IDLE;
        if (capture) begin
          idx_d   = HADDR[IW+1:2];
          lo_d    = HADDR[1:0];
          size_d  = HSIZE[1:0];
          write_d = HWRITE;
          if (addr_err) begin
            st_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            st_d  = ST_WAIT;
            cnt_d = 4'(WAIT_STATES);
          end else begin
            st_d = ST_ACCESS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      st_q    <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lo_q    <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << lo_q;
      2'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Commit happens on the edge that ends ACCESS; a reset on that edge drops it
  always_ff @(posedge HCLK) begin
    if (!HRESET && st_q == ST_ACCESS && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    case (st_q)
      ST_WAIT:   HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2:   HRESP = 1'b1;
      ST_ACCESS: if (!write_q) HRDATA = mem[idx_q];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_sram_slv.sv
// Bench for ahb_lite_sram_slv: a zero-wait and a three-wait instance, driven by a
// pipelined master against an in-order memory model.
module tb_ahb_lite_sram_slv;

  localparam int DEPTH = 16;
  localparam int WS1   = 3;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel0, hsel3;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        ro0, ro3, rs0, rs3;
  logic [31:0] rd0, rd3;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slv #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(ro0), .HWDATA(HWDATA),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

  ahb_lite_sram_slv #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) u3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(ro3), .HWDATA(HWDATA),
    .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3));

  typedef struct {
    logic        wr;
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        use_tab;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_wait;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          cur   = 0;
  logic [31:0] refm [2][DEPTH];
  vec_t        q[$];
  vec_t        tab [16];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h want=%h t=%0t", nm, cur, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(logic wr, logic sel, logic [1:0] tr, logic [2:0] sz,
                              logic [31:0] a, logic [31:0] wd, logic ut, logic ee,
                              logic [31:0] er);
    vec_t v;
    v.wr = wr; v.sel = sel; v.trans = tr; v.size = sz; v.addr = a; v.wdata = wd;
    v.use_tab = ut; v.exp_err = ee; v.exp_rdata = er; v.exp_wait = 0;
    return v;
  endfunction

  // Reference: error rules, lane selection and wait length straight from the bus rules
  function automatic void model(inout vec_t v);
    logic [29:0] w;
    logic        cap, err, lane;
    int          ws;
    w   = v.addr[31:2];
    cap = v.sel && v.trans[1];
    err = cap && ((v.size > 3'd2) || (v.size == 3'd1 && v.addr[0]) ||
                  (v.size == 3'd2 && v.addr[1:0] != 2'b00) || ({2'b00, w} >= 32'(DEPTH)));
    ws  = (cur == 0) ? 0 : WS1;
    if (!v.use_tab) begin
      v.exp_err   = err;
      v.exp_rdata = (cap && !err && !v.wr) ? refm[cur][w[3:0]] : 32'h0;
    end
    v.exp_wait = !cap ? 0 : (v.exp_err ? 1 : ws);
    if (cap && !err && v.wr) begin
      for (int b = 0; b < 4; b++) begin
        case (v.size)
          3'd0:    lane = (b == int'(v.addr[1:0]));
          3'd1:    lane = ((b / 2) == int'(v.addr[1]));
          default: lane = 1'b1;
        endcase
        if (lane) refm[cur][w[3:0]][8*b +: 8] = v.wdata[8*b +: 8];
      end
    end
  endfunction

  function automatic void push(vec_t v);
    vec_t t;
    t = v;
    model(t);
    q.push_back(t);
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
           ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
           ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 71)),
           $urandom, 1'b0, 1'b0, 32'h0);
    if ($urandom_range(0, 3) != 0) begin
      if (v.size == 3'd1) v.addr[0] = 1'b0;
      if (v.size == 3'd2) v.addr[1:0] = 2'b00;
    end
    return v;
  endfunction

  task automatic drive_addr(input vec_t v);
    HADDR     = v.addr;
    HWRITE    = v.wr;
    HSIZE     = v.size;
    HTRANS    = v.trans;
    HBURST    = 3'($urandom_range(0, 7));
    HPROT     = 4'($urandom_range(0, 15));
    HMASTLOCK = 1'($urandom_range(0, 1));
    hsel0     = (cur == 0) ? v.sel : 1'b0;
    hsel3     = (cur == 1) ? v.sel : 1'b0;
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench stopped on timeout");
  endtask

  // Pipelined master: next address phase overlaps the current data phase
  task automatic run_q();
    int          ai = 0;
    int          wc = 0;
    int          guard = 0;
    bit          d_v = 0;
    vec_t        d, idle_v;
    logic        rdy, rsp;
    logic [31:0] rdat;
    idle_v = mk(0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    d = idle_v;
    while (ai < q.size() || d_v) begin
      if (ai < q.size()) drive_addr(q[ai]); else drive_addr(idle_v);
      HWDATA = d_v ? d.wdata : 32'h0;
      @(negedge HCLK);
      rdy  = (cur == 0) ? ro0 : ro3;
      rsp  = (cur == 0) ? rs0 : rs3;
      rdat = (cur == 0) ? rd0 : rd3;
      if (!d_v) begin
        check("idle_ready", 32'(rdy), 32'd1);
        check("idle_resp", 32'(rsp), 32'd0);
      end else if (!rdy) begin
        check("stall_allowed", 32'(wc < d.exp_wait), 32'd1);
        check("stall_resp", 32'(rsp), 32'(d.exp_err));
        check("stall_rdata", rdat, 32'h0);
        wc++;
      end else begin
        check("wait_len", 32'(wc), 32'(d.exp_wait));
        check("resp", 32'(rsp), 32'(d.exp_err));
        check("rdata", rdat, d.exp_rdata);
      end
      guard++;
      if (guard > 40) begin
        total++;
        bad++;
        $display("FAIL timeout dut=%0d HREADYOUT stuck low", cur);
        finish_now();
      end
      @(posedge HCLK);
      #1;
      if (rdy) begin
        d_v = (ai < q.size());
        if (d_v) d = q[ai];
        ai++;
        wc    = 0;
        guard = 0;
      end
    end
    drive_addr(idle_v);
    HWDATA = 32'h0;
    q.delete();
  endtask

  initial begin
    vec_t v, idle_v;
    idle_v = mk(0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    HRESET = 1'b1;
    HWDATA = 32'h0;
    drive_addr(idle_v);
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rst_ready0", 32'(ro0), 32'd1);
    check("rst_resp0", 32'(rs0), 32'd0);
    check("rst_rdata0", rd0, 32'h0);
    check("rst_ready3", 32'(ro3), 32'd1);
    @(posedge HCLK);
    #1;

    for (int c = 0; c < 2; c++) begin
      cur = c;
      for (int i = 0; i < DEPTH; i++)
        push(mk(1, 1, 2'd2, 3'd2, 32'(4 * i), $urandom, 1'b0, 1'b0, 32'h0));
      run_q();
    end

    // write before reset, then reset two cycles; memory must survive
    cur = 0;
    push(mk(1, 1, 2'd2, 3'd2, 32'h10, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0));
    run_q();
    HRESET = 1'b1;
    repeat (2) begin
      @(negedge HCLK);
      @(posedge HCLK);
      #1;
    end
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rst2_ready", 32'(ro0), 32'd1);
    check("rst2_resp", 32'(rs0), 32'd0);
    check("rst2_rdata", rd0, 32'h0);
    @(posedge HCLK);
    #1;

    tab[0]  = mk(0, 1, 2'd2, 3'd2, 32'h10, 32'h0,         1, 0, 32'hCAFE_0001);
    tab[1]  = mk(1, 1, 2'd2, 3'd2, 32'h08, 32'hDEAD_BEEF, 1, 0, 32'h0);
    tab[2]  = mk(0, 1, 2'd2, 3'd2, 32'h08, 32'h0,         1, 0, 32'hDEAD_BEEF);
    tab[3]  = mk(1, 1, 2'd2, 3'd2, 32'h04, 32'h1122_3344, 1, 0, 32'h0);
    tab[4]  = mk(1, 1, 2'd2, 3'd0, 32'h05, 32'h0000_AA00, 1, 0, 32'h0);
    tab[5]  = mk(1, 1, 2'd2, 3'd1, 32'h06, 32'hBBBB_0000, 1, 0, 32'h0);
    tab[6]  = mk(0, 1, 2'd2, 3'd2, 32'h04, 32'h0,         1, 0, 32'hBBBB_AA44);
    tab[7]  = mk(1, 1, 2'd2, 3'd1, 32'h03, 32'hFFFF_FFFF, 1, 1, 32'h0);
    tab[8]  = mk(1, 1, 2'd2, 3'd2, 32'h02, 32'hFFFF_FFFF, 1, 1, 32'h0);
    tab[9]  = mk(1, 1, 2'd2, 3'd3, 32'h04, 32'hFFFF_FFFF, 1, 1, 32'h0);
    tab[10] = mk(1, 1, 2'd2, 3'd2, 32'h40, 32'hFFFF_FFFF, 1, 1, 32'h0);
    tab[11] = mk(0, 1, 2'd2, 3'd2, 32'h04, 32'h0,         1, 0, 32'hBBBB_AA44);
    tab[12] = mk(1, 1, 2'd0, 3'd2, 32'h04, 32'h0,         1, 0, 32'h0);
    tab[13] = mk(1, 1, 2'd1, 3'd2, 32'h04, 32'h0,         1, 0, 32'h0);
    tab[14] = mk(1, 0, 2'd2, 3'd2, 32'h04, 32'h0,         1, 0, 32'h0);
    tab[15] = mk(0, 1, 2'd3, 3'd0, 32'h05, 32'h0,         1, 0, 32'hBBBB_AA44);
    for (int i = 0; i < 16; i++) push(tab[i]);
    run_q();

    // three-wait instance: exact stall lengths, errors, pipelined follow-on
    cur = 1;
    push(mk(1, 1, 2'd2, 3'd2, 32'h08, 32'h1234_5678, 1'b0, 1'b0, 32'h0));
    push(mk(0, 1, 2'd2, 3'd2, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0));
    push(mk(0, 1, 2'd2, 3'd1, 32'h03, 32'h0, 1'b0, 1'b0, 32'h0));
    push(mk(1, 1, 2'd2, 3'd2, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0));
    push(mk(0, 1, 2'd2, 3'd2, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0));
    run_q();

    // reset during a write's wait phase aborts it
    v = mk(1, 1, 2'd2, 3'd2, 32'h20, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
    drive_addr(v);
    @(posedge HCLK);
    #1;
    drive_addr(idle_v);
    HWDATA = v.wdata;
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midwait_ready", 32'(ro3), 32'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check("postrst_ready", 32'(ro3), 32'd1);
    check("postrst_resp", 32'(rs3), 32'd0);
    @(posedge HCLK);
    #1;
    push(mk(0, 1, 2'd2, 3'd2, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0));
    run_q();

    for (int c = 0; c < 2; c++) begin
      cur = c;
      for (int i = 0; i < 80; i++) push(rnd_vec());
      run_q();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slv.md
Name: ahb_lite_sram_slv

Overview:
AHB-Lite subordinate (responder) that completes transfers issued by the master-side agent over the same HCLK bus. It is backed by a register-array memory with a programmable number of wait states. The block decodes address and control in the address phase and returns HREADYOUT, HRESP and HRDATA in the data phase. It is the DUT-side counterpart used to close the AHB-Lite loop in simulation, and it is synthesizable.

Parameters:
MEM_DEPTH, 256, memory size in 32-bit words; must be a power of two, ≥4
WAIT_STATES, 0, HREADYOUT-low cycles inserted before every OKAY data-phase completion (0..15)

Ports:
HCLK  input  1  bus clock, all logic on rising edge
HRESET  input  1  synchronous reset, active-high
HSEL  input  1  slave select from decoder
HADDR  input  32  byte address
HWRITE  input  1  1=write, 0=read
HSIZE  input  3  transfer size
HBURST  input  3  burst type; accepted, not interpreted
HPROT  input  4  protection; ignored
HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HMASTLOCK  input  1  ignored
HREADY  input  1  bus-level ready from interconnect mux
HWDATA  input  32  write data, data phase
HREADYOUT  output  1  slave ready
HRESP  output  1  0=OKAY, 1=ERROR
HRDATA  output  32  read data

Behaviour:
- Reset (HRESET=1 at an HCLK edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, latched address/control cleared. Memory contents are not cleared. Reset asserted mid-transfer aborts the transfer; a pending write is not committed.
- Address-phase capture: occurs at an edge with HSEL=1, HREADY=1 and HTRANS[1]=1. It latches HADDR, HWRITE and HSIZE. Any other address phase, including BUSY or HSEL=0, yields IDLE next; IDLE gives HREADYOUT=1, HRESP=0.
- Error check at capture. ERROR applies if any of the following holds:
  - HSIZE>2;
  - HSIZE=1 with HADDR[0]≠0;
  - HSIZE=2 with HADDR[1:0]≠0;
  - word index HADDR[31:2] ≥ MEM_DEPTH.
- States:
  - IDLE: no data phase.
  - WAIT: HREADYOUT=0, HRESP=0; counter runs from WAIT_STATES down to 1.
  - ACCESS: final OKAY cycle; HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - A valid capture goes to WAIT if WAIT_STATES>0, else to ACCESS.
  - WAIT goes to ACCESS when the counter reaches 1.
  - An invalid capture goes to ERR1; ERR1 always goes to ERR2.
  - ACCESS and ERR2 reload from the address phase sampled at that same edge, so pipelined back-to-back transfers need no idle cycle.
  - In WAIT and ERR1, address-phase inputs are ignored because HREADY=0.
- Errored transfers never write memory. HRDATA=0 during ERR1 and ERR2.
- Write commit: at the rising edge that ends ACCESS, byte lanes are written from HWDATA, little-endian:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
  - Unselected lanes are unchanged.
- Read: HRDATA carries the full 32-bit word at the latched index during ACCESS of a read; otherwise HRDATA=0. The master extracts the lanes it needs.
- Read-after-write to the same address with 0 wait states returns the new data, because the write commits before the read's data phase.
- Wait-state latency: a transfer's data phase lasts WAIT_STATES+1 cycles; an error lasts exactly 2 cycles.

Test Plan:
- Reset: HRESET=1 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0; a prior write to 0x10 still reads back afterwards.
- Word write/read, WAIT_STATES=0: NONSEQ write 0x0000_0008 data 0xDEAD_BEEF, then NONSEQ read 0x8 back-to-back -> HREADYOUT never low, read data phase HRDATA=0xDEAD_BEEF.
- Byte lanes: word 0x4 = 0x1122_3344; byte write 0xAA to 0x5 (HWDATA=0x0000_AA00); halfword write 0xBBBB to 0x6 (HWDATA=0xBBBB_0000) -> read 0x4 returns 0xBBBB_AA44.
- Wait states, WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, then 1 cycle high with valid data; next address phase is accepted only on that high cycle.
- Errors: halfword at 0x3, word at 0x2, HSIZE=3, and address 4*MEM_DEPTH -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; memory unchanged; the following valid transfer completes OKAY.
- IDLE/BUSY/HSEL=0 and reset mid-WAIT: these address phases give zero-wait OKAY. HRESET during a write WAIT -> next cycle IDLE, and the target word retains its old value.
